// File: rtl/pic_pkg.sv
// Shared types, widths and rotating-priority helpers for the PIC interrupt sequencer.
package pic_pkg;

  localparam int unsigned IR_W  = 8;
  localparam int unsigned LVL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } pic_state_e;

  typedef struct packed {
    logic             valid;
    logic [LVL_W-1:0] level;
  } prio_t;

  // Highest-priority set bit of vec, scanning lp+1, lp+2 ... lp (mod 8).
  function automatic prio_t prio_encode(input logic [IR_W-1:0] vec, input logic [LVL_W-1:0] lp);
    prio_t            res;
    logic [LVL_W-1:0] lvl;
    res = '0;
    for (int unsigned k = 1; k <= IR_W; k++) begin
      lvl = lp + LVL_W'(k);
      if (vec[lvl] && !res.valid) begin
        res.valid = 1'b1;
        res.level = lvl;
      end
    end
    return res;
  endfunction

  // Position of a level in the current priority order; 0 is highest.
  function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] level,
                                                 input logic [LVL_W-1:0] lp);
    return level - lp - LVL_W'(1);
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Combinational rotating-priority resolver: picks the highest-priority set bit for a given lp.
import pic_pkg::*;

module pic_prio_resolver (
  input  logic [IR_W-1:0]  vec,
  input  logic [LVL_W-1:0] lp,
  output logic             valid_c,
  output logic [LVL_W-1:0] level_c
);

  prio_t res;

  always_comb begin
    res = prio_encode(vec, lp);
  end

  assign valid_c = res.valid;
  assign level_c = res.level;

endmodule

// File: rtl/pic_irq_sequencer.sv
// 8259A-style interrupt core: IRR/ISR/IMR, nested rotating priority, INT and two-pulse INTA vector.
// Optional macro PIC_IR_SYNC_EN adds 2-flop synchronisers on ir and inta_n.
import pic_pkg::*;

module pic_irq_sequencer #(
  parameter int unsigned SPUR_LEVEL = 7,
  parameter int unsigned LP_RESET   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IR_W-1:0]  ir,
  input  logic             inta_n,
  input  logic             init_pulse,
  input  logic             ltim,
  input  logic [4:0]       vec_base,
  input  logic             aeoi,
  input  logic             imr_wr,
  input  logic [IR_W-1:0]  imr_data,
  input  logic             eoi_ns,
  input  logic             eoi_sp,
  input  logic [LVL_W-1:0] eoi_level,
  input  logic             rotate,
  output logic             int_o,
  output logic [7:0]       vec_out,
  output logic             vec_oe,
  output logic [IR_W-1:0]  irr_o,
  output logic [IR_W-1:0]  isr_o
);

  logic [IR_W-1:0] ir_s;
  logic            inta_s;

`ifdef PIC_IR_SYNC_EN
  logic [IR_W-1:0] ir_m;
  logic            inta_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_m   <= '0;
      ir_s   <= '0;
      inta_m <= 1'b1;
      inta_s <= 1'b1;
    end else begin
      ir_m   <= ir;
      ir_s   <= ir_m;
      inta_m <= inta_n;
      inta_s <= inta_m;
    end
  end
`else
  assign ir_s   = ir;
  assign inta_s = inta_n;
`endif

  pic_state_e       state, state_d;
  logic [IR_W-1:0]  irr, irr_d, isr, isr_d, imr, imr_d;
  logic [LVL_W-1:0] lp, lp_d, grant, grant_d;
  logic             spur, spur_d;
  logic             int_d, vec_oe_d;
  logic [7:0]       vec_out_d;
  logic [IR_W-1:0]  ir_prev;
  logic             inta_prev;

  logic [IR_W-1:0]  req_masked, ir_rise;
  logic             inta_fall;
  logic             cand_valid, top_valid;
  logic [LVL_W-1:0] cand_level, top_level;

  assign req_masked = irr & ~imr;
  assign ir_rise    = ir_s & ~ir_prev;
  assign inta_fall  = inta_prev & ~inta_s;

  pic_prio_resolver u_cand (
    .vec     (req_masked),
    .lp      (lp),
    .valid_c (cand_valid),
    .level_c (cand_level)
  );

  pic_prio_resolver u_top (
    .vec     (isr),
    .lp      (lp),
    .valid_c (top_valid),
    .level_c (top_level)
  );

  // Next-state, register updates and registered outputs.
  always_comb begin
    state_d   = state;
    irr_d     = ltim ? ir_s : irr;
    isr_d     = isr;
    imr_d     = imr;
    lp_d      = lp;
    grant_d   = grant;
    spur_d    = spur;
    int_d     = cand_valid &&
                (!top_valid || (prio_rank(cand_level, lp) < prio_rank(top_level, lp)));
    vec_oe_d  = 1'b0;
    vec_out_d = '0;

    if (init_pulse) begin
      state_d = IDLE;
      irr_d   = '0;
      isr_d   = '0;
      imr_d   = '0;
      lp_d    = LVL_W'(LP_RESET);
      grant_d = '0;
      spur_d  = 1'b0;
      int_d   = 1'b0;
    end else begin
      if (eoi_sp) begin
        isr_d[eoi_level] = 1'b0;
        if (rotate) lp_d = eoi_level;
      end else if (eoi_ns && top_valid) begin
        isr_d[top_level] = 1'b0;
        if (rotate) lp_d = top_level;
      end

      case (state)
        IDLE: begin
          if (inta_fall) state_d = ACK1;
        end
        ACK1: begin
          if (cand_valid) begin
            grant_d           = cand_level;
            spur_d            = 1'b0;
            isr_d[cand_level] = 1'b1;
            irr_d[cand_level] = 1'b0;
          end else begin
            grant_d = LVL_W'(SPUR_LEVEL);
            spur_d  = 1'b1;
          end
          state_d = WAIT2;
        end
        WAIT2: begin
          if (inta_fall) state_d = ACK2;
        end
        ACK2: begin
          if (inta_s) begin
            state_d = IDLE;
            if (aeoi && !spur) isr_d[grant] = 1'b0;
            if (aeoi && rotate) lp_d = grant;
          end
        end
        default: state_d = IDLE;
      endcase

      // A fresh edge wins over the ACK1 clear of the same bit.
      irr_d = irr_d | ir_rise;

      if (imr_wr) imr_d = imr_data;

      vec_oe_d  = (state_d == ACK2);
      vec_out_d = vec_oe_d ? {vec_base, grant_d} : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irr       <= '0;
      isr       <= '0;
      imr       <= '0;
      lp        <= LVL_W'(LP_RESET);
      grant     <= '0;
      spur      <= 1'b0;
      int_o     <= 1'b0;
      vec_oe    <= 1'b0;
      vec_out   <= '0;
      ir_prev   <= '0;
      inta_prev <= 1'b1;
    end else begin
      state     <= state_d;
      irr       <= irr_d;
      isr       <= isr_d;
      imr       <= imr_d;
      lp        <= lp_d;
      grant     <= grant_d;
      spur      <= spur_d;
      int_o     <= int_d;
      vec_oe    <= vec_oe_d;
      vec_out   <= vec_out_d;
      ir_prev   <= ir_s;
      inta_prev <= inta_s;
    end
  end

  assign irr_o = irr;
  assign isr_o = isr;

endmodule

// File: tb/tb_pic_irq_sequencer.sv
// Self-checking bench for pic_irq_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_pic_irq_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir;
  logic       inta_n;
  logic       init_pulse;
  logic       ltim;
  logic [4:0] vec_base;
  logic       aeoi;
  logic       imr_wr;
  logic [7:0] imr_data;
  logic       eoi_ns;
  logic       eoi_sp;
  logic [2:0] eoi_level;
  logic       rotate;
  logic       int_o;
  logic [7:0] vec_out;
  logic       vec_oe;
  logic [7:0] irr_o;
  logic [7:0] isr_o;

  int n_checks = 0;
  int n_errors = 0;

  pic_irq_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir         (ir),
    .inta_n     (inta_n),
    .init_pulse (init_pulse),
    .ltim       (ltim),
    .vec_base   (vec_base),
    .aeoi       (aeoi),
    .imr_wr     (imr_wr),
    .imr_data   (imr_data),
    .eoi_ns     (eoi_ns),
    .eoi_sp     (eoi_sp),
    .eoi_level  (eoi_level),
    .rotate     (rotate),
    .int_o      (int_o),
    .vec_out    (vec_out),
    .vec_oe     (vec_oe),
    .irr_o      (irr_o),
    .isr_o      (isr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: sequence phase 0 idle, 1 first ack, 2 waiting second pulse, 3 driving vector.
  logic [7:0] m_irr, m_isr, m_imr, m_vec, m_ir_prev;
  logic       m_int, m_oe, m_inta_prev, m_spur;
  int         m_lp, m_seq, m_grant;

  function automatic int best(input logic [7:0] v, input int lp);
    for (int k = 1; k <= 8; k++) begin
      if (v[(lp + k) % 8]) return (lp + k) % 8;
    end
    return -1;
  endfunction

  function automatic int rank(input int l, input int lp);
    return (l - lp + 15) % 8;
  endfunction

  task automatic model_reset();
    m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_vec = 8'h00;
    m_int = 1'b0; m_oe = 1'b0; m_spur = 1'b0;
    m_lp = 7; m_seq = 0; m_grant = 0;
  endtask

  task automatic model_step();
    int         c, t, n_lp, n_seq, n_grant;
    logic [7:0] n_irr, n_isr;
    logic       fall, n_spur;
    c    = best(m_irr & ~m_imr, m_lp);
    t    = best(m_isr, m_lp);
    fall = m_inta_prev && !inta_n;
    if (init_pulse) begin
      model_reset();
    end else begin
      m_int   = (c >= 0) && (t < 0 || rank(c, m_lp) < rank(t, m_lp));
      n_irr   = ltim ? ir : m_irr;
      n_isr   = m_isr;
      n_lp    = m_lp;
      n_seq   = m_seq;
      n_grant = m_grant;
      n_spur  = m_spur;
      if (eoi_sp) begin
        n_isr[eoi_level] = 1'b0;
        if (rotate) n_lp = int'(eoi_level);
      end else if (eoi_ns && t >= 0) begin
        n_isr[t] = 1'b0;
        if (rotate) n_lp = t;
      end
      if (m_seq == 0) begin
        if (fall) n_seq = 1;
      end else if (m_seq == 1) begin
        if (c < 0) begin
          n_grant = 7;
          n_spur  = 1'b1;
        end else begin
          n_grant  = c;
          n_spur   = 1'b0;
          n_isr[c] = 1'b1;
          n_irr[c] = 1'b0;
        end
        n_seq = 2;
      end else if (m_seq == 2) begin
        if (fall) n_seq = 3;
      end else begin
        if (inta_n) begin
          n_seq = 0;
          if (aeoi && !m_spur) n_isr[m_grant] = 1'b0;
          if (aeoi && rotate) n_lp = m_grant;
        end
      end
      n_irr = n_irr | (ir & ~m_ir_prev);
      if (imr_wr) m_imr = imr_data;
      m_irr   = n_irr;
      m_isr   = n_isr;
      m_lp    = n_lp;
      m_seq   = n_seq;
      m_grant = n_grant;
      m_spur  = n_spur;
      m_oe    = (n_seq == 3);
      m_vec   = m_oe ? {vec_base, 3'(n_grant)} : 8'h00;
    end
    m_ir_prev   = ir;
    m_inta_prev = inta_n;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("int_o",   {7'b0, int_o},  {7'b0, m_int});
    chk("vec_oe",  {7'b0, vec_oe}, {7'b0, m_oe});
    chk("vec_out", vec_out, m_vec);
    chk("irr_o",   irr_o,   m_irr);
    chk("isr_o",   isr_o,   m_isr);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_init();
    ir = 8'h00;
    init_pulse = 1'b1;
    tick();
    init_pulse = 1'b0;
  endtask

  task automatic inta_first();
    inta_n = 1'b0; tick(); tick();
    inta_n = 1'b1; tick(); tick();
  endtask

  task automatic inta_second(output logic [7:0] v);
    inta_n = 1'b0; tick();
    v = vec_out;
    tick();
    inta_n = 1'b1; tick();
  endtask

  logic [7:0] v;

  initial begin
    rst_n = 1'b0; ir = 8'h00; inta_n = 1'b1; init_pulse = 1'b0; ltim = 1'b0;
    vec_base = 5'h11; aeoi = 1'b0; imr_wr = 1'b0; imr_data = 8'h00;
    eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_level = 3'd0; rotate = 1'b0;
    model_reset();
    m_ir_prev = 8'h00; m_inta_prev = 1'b1;
    #12;
    chk("reset_int", {7'b0, int_o}, 8'h00);
    chk("reset_oe",  {7'b0, vec_oe}, 8'h00);
    chk("reset_vec", vec_out, 8'h00);
    chk("reset_irr", irr_o, 8'h00);
    chk("reset_isr", isr_o, 8'h00);
    rst_n = 1'b1;
    #1;

    // Basic edge-mode grant of IR2 with IR5 pending.
    ir = 8'h24; tick(); tick();
    chk("basic_int", {7'b0, int_o}, 8'h01);
    inta_first();
    chk("basic_isr", isr_o, 8'h04);
    chk("basic_irr", irr_o, 8'h20);
    chk("model_isr", m_isr, 8'h04);
    inta_second(v);
    chk("basic_vec", v, 8'h8A);
    eoi_ns = 1'b1; tick(); eoi_ns = 1'b0;
    chk("basic_eoi_isr", isr_o, 8'h00);
    tick();
    chk("basic_reint", {7'b0, int_o}, 8'h01);

    // Fully nested: lower priority blocked, higher priority interrupts.
    do_init();
    ir = 8'h08; tick(); tick();
    inta_first(); inta_second(v);
    chk("nest_isr", isr_o, 8'h08);
    ir = 8'h28; tick(); tick();
    chk("nest_low_int", {7'b0, int_o}, 8'h00);
    ir = 8'h2A; tick(); tick();
    chk("nest_high_int", {7'b0, int_o}, 8'h01);

    // Rotate on non-specific EOI.
    do_init();
    ir = 8'h10; tick(); tick();
    inta_first(); inta_second(v);
    chk("rot_isr", isr_o, 8'h10);
    rotate = 1'b1; eoi_ns = 1'b1; tick(); eoi_ns = 1'b0; rotate = 1'b0;
    chk("model_lp", 8'(m_lp), 8'h04);
    ir = 8'h00; tick();
    ir = 8'h11; tick(); tick();
    inta_first(); inta_second(v);
    chk("rot_vec", v, 8'h88);
    chk("rot_isr2", isr_o, 8'h01);

    // Spurious acknowledge with IR7 in service and AEOI on.
    do_init();
    ir = 8'h80; tick(); tick();
    inta_first(); inta_second(v);
    ir = 8'h00; tick();
    ltim = 1'b1; aeoi = 1'b1;
    ir = 8'h04; tick(); tick();
    chk("spur_int", {7'b0, int_o}, 8'h01);
    ir = 8'h00;
    inta_first(); inta_second(v);
    chk("spur_vec", v, 8'h8F);
    chk("spur_isr", isr_o, 8'h80);
    ltim = 1'b0;

    // Auto-EOI clears ISR at the end of the second pulse.
    do_init();
    ir = 8'h40; tick(); tick();
    inta_first();
    ir = 8'hC0;
    inta_second(v);
    chk("aeoi_vec", v, 8'h8E);
    chk("aeoi_isr", isr_o, 8'h00);
    chk("aeoi_irr", irr_o, 8'h80);
    tick();
    chk("aeoi_int", {7'b0, int_o}, 8'h01);
    aeoi = 1'b0;

    // Masking a pending request.
    do_init();
    ir = 8'h08; tick(); tick();
    chk("mask_int_pre", {7'b0, int_o}, 8'h01);
    imr_wr = 1'b1; imr_data = 8'h08; tick(); imr_wr = 1'b0;
    tick();
    chk("mask_int_post", {7'b0, int_o}, 8'h00);

    // init_pulse in WAIT2 aborts the sequence and clears IMR.
    do_init();
    imr_wr = 1'b1; imr_data = 8'hF0; tick(); imr_wr = 1'b0;
    ir = 8'h02; tick(); tick();
    inta_first();
    init_pulse = 1'b1; tick(); init_pulse = 1'b0;
    chk("init_isr", isr_o, 8'h00);
    chk("init_oe", {7'b0, vec_oe}, 8'h00);
    inta_second(v);
    chk("init_novec", v, 8'h00);
    ir = 8'h22; tick(); tick();
    chk("init_imr_clr_int", {7'b0, int_o}, 8'h01);

    // Random traffic.
    for (int chunk = 0; chunk < 4; chunk++) begin
      do_init();
      ltim     = chunk[0];
      aeoi     = chunk[1];
      vec_base = 5'($urandom_range(0, 31));
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 3) == 0) ir[$urandom_range(0, 7)] ^= 1'b1;
        if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
        eoi_ns     = ($urandom_range(0, 11) == 0);
        eoi_sp     = ($urandom_range(0, 15) == 0);
        eoi_level  = 3'($urandom_range(0, 7));
        rotate     = 1'($urandom_range(0, 1));
        imr_wr     = ($urandom_range(0, 19) == 0);
        imr_data   = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
        init_pulse = ($urandom_range(0, 199) == 0);
        tick();
      end
      eoi_ns = 1'b0; eoi_sp = 1'b0; rotate = 1'b0; imr_wr = 1'b0; init_pulse = 1'b0;
      inta_n = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
